ppu_frame_capture: RTL and testbench

Pixel sink for the PPU output stream.
- Consumes PX_OUT/PX_valid and tracks the current line and frame from PPU_MODE transitions.
- Packs 2-bit pixels four per byte, queues the bytes in a small FIFO and writes them into a 160x144 frame-buffer RAM over a valid/ready write port.
- Sits between the PPU and the frame-buffer/VGA scan-out.

---
 rtl/ppu_frame_capture.sv | 204 ++++++++++++++++++++
 tb/tb_ppu_frame_capture.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_frame_capture.sv
// Pixel sink between the PPU and the frame buffer. It packs 2-bit pixels four per byte,
// queues the bytes in a small FIFO and writes them out over a valid/ready port.
module ppu_frame_capture #(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 144,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  output logic        FB_WE,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_WDATA,
  input  logic        FB_READY,
  input  logic        STATUS_CLR,
  output logic        FRAME_DONE,
  output logic        OVERFLOW,
  output logic        LINE_ERR
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0]       H_MAX     = 8'(H_PIXELS);
  localparam logic [7:0]       V_MAX     = 8'(V_LINES);
  localparam logic [12:0]      BYTES_PL  = 13'(H_PIXELS / 4);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    M_HBLANK = 2'd0,
    M_VBLANK = 2'd1,
    M_SCAN   = 2'd2,
    M_DRAW   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } fb_word_t;

  state_t           state, state_nxt;
  logic [1:0]       prev_mode;
  logic [7:0]       x, y;
  logic [5:0]       pack;
  logic [1:0]       pack_cnt;
  logic             frame_done_q, frame_done_nxt;
  logic             overflow_q, line_err_q;

  fb_word_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             vb_to_scan, vb_entry, line_end;
  logic             draw_px, px_accept, px_drop, line_done;
  logic             push, push_ok, pop, full;
  logic             overflow_set, line_err_set;
  logic [12:0]      cur_addr;
  logic [7:0]       partial;
  fb_word_t         push_word, head;

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    vb_to_scan = (prev_mode == M_VBLANK) && (PPU_MODE == M_SCAN);
    vb_entry   = (prev_mode != M_VBLANK) && (PPU_MODE == M_VBLANK);
    line_end   = (prev_mode == M_DRAW)   && (PPU_MODE == M_HBLANK);
    draw_px    = (state == S_ACTIVE) && PX_valid && (PPU_MODE == M_DRAW);
    px_accept  = draw_px && (x < H_MAX) && (y < V_MAX);
    px_drop    = draw_px && !((x < H_MAX) && (y < V_MAX));
    line_done  = (state == S_ACTIVE) && line_end;
    cur_addr   = y * BYTES_PL + 13'(x[7:2]);

    // Missing trailing pixels of a short group read as colour 0.
    unique case (pack_cnt)
      2'd1:    partial = {pack[1:0], 6'b0};
      2'd2:    partial = {pack[3:0], 4'b0};
      2'd3:    partial = {pack[5:0], 2'b0};
      default: partial = 8'h00;
    endcase

    push      = 1'b0;
    push_word = '0;
    if (LCD_EN) begin
      if (px_accept && pack_cnt == 2'd3) begin
        push      = 1'b1;
        push_word = '{addr: cur_addr, data: {pack, PX_OUT}};
      end else if ((line_done || state == S_FLUSH) && pack_cnt != 2'd0) begin
        push      = 1'b1;
        push_word = '{addr: cur_addr, data: partial};
      end
    end

    pop          = FB_WE && FB_READY;
    full         = (count == FIFO_FULL);
    push_ok      = push && (!full || pop);
    overflow_set = push && full && !pop;
    line_err_set = LCD_EN && (px_drop || (line_done && x != H_MAX));
  end

  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    if (!LCD_EN) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (vb_to_scan) state_nxt = S_ACTIVE;
        S_ACTIVE: if (vb_entry) state_nxt = S_FLUSH;
        S_FLUSH: begin
          if (count == '0 && pack_cnt == 2'd0) begin
            state_nxt      = S_IDLE;
            frame_done_nxt = 1'b1;
          end
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      prev_mode    <= M_HBLANK;
      x            <= '0;
      y            <= '0;
      pack         <= '0;
      pack_cnt     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev_mode    <= PPU_MODE;
      frame_done_q <= frame_done_nxt;
      if (!LCD_EN || (state == S_IDLE && vb_to_scan)) begin
        x        <= '0;
        y        <= '0;
        pack     <= '0;
        pack_cnt <= '0;
      end else if (px_accept) begin
        x        <= x + 8'd1;
        pack     <= {pack[3:0], PX_OUT};
        pack_cnt <= pack_cnt + 2'd1;
      end else if (line_done) begin
        x        <= '0;
        y        <= (y < V_MAX) ? y + 8'd1 : y;
        pack     <= '0;
        pack_cnt <= '0;
      end else if (state == S_FLUSH) begin
        pack_cnt <= '0;
      end
    end
  end

  // Disabling the LCD discards queued bytes exactly like a reset does.
  always_ff @(posedge clk) begin
    if (!rst || !LCD_EN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the FIFO storage needs no reset; an entry is only observed once count
  // covers it, and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_set | (overflow_q & ~STATUS_CLR);
      line_err_q <= line_err_set | (line_err_q & ~STATUS_CLR);
    end
  end

  assign head       = mem[rd_ptr];
  assign FB_WE      = (count != '0);
  assign FB_ADDR    = FB_WE ? head.addr : '0;
  assign FB_WDATA   = FB_WE ? head.data : '0;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;
  assign LINE_ERR   = line_err_q;

endmodule

// File: tb/tb_ppu_frame_capture.sv
// Bench for ppu_frame_capture: stimulus pushes expected frame-buffer writes computed from
// the pixel lists into a scoreboard; a monitor pops and compares on each accepted write.
module tb_ppu_frame_capture;

  localparam int H   = 160;
  localparam int V   = 144;
  localparam int D   = 4;
  localparam int BPL = H / 4;

  localparam logic [1:0] HBLANK = 2'd0;
  localparam logic [1:0] VBLANK = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;
  localparam logic [1:0] DRAW   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic [1:0]  PX_OUT;
  logic        PX_valid;
  logic        FB_WE;
  logic [12:0] FB_ADDR;
  logic [7:0]  FB_WDATA;
  logic        FB_READY;
  logic        STATUS_CLR;
  logic        FRAME_DONE;
  logic        OVERFLOW;
  logic        LINE_ERR;

  ppu_frame_capture #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .LCD_EN     (LCD_EN),
    .PPU_MODE   (PPU_MODE),
    .PX_OUT     (PX_OUT),
    .PX_valid   (PX_valid),
    .FB_WE      (FB_WE),
    .FB_ADDR    (FB_ADDR),
    .FB_WDATA   (FB_WDATA),
    .FB_READY   (FB_READY),
    .STATUS_CLR (STATUS_CLR),
    .FRAME_DONE (FRAME_DONE),
    .OVERFLOW   (OVERFLOW),
    .LINE_ERR   (LINE_ERR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fd_cnt = 0;
  int         ready_ctl = 1;  // 0 stuck low, 1 stuck high, 2 random (never low 3 cycles running)
  bit         exp_err = 0;
  logic [1:0] cur_mode = HBLANK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FB_READY driver
  always @(posedge clk) begin
    int lows;
    #1;
    case (ready_ctl)
      0:       FB_READY = 1'b0;
      1:       FB_READY = 1'b1;
      default: FB_READY = (lows >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
    endcase
    lows = FB_READY ? 0 : lows + 1;
  end

  // Write / status monitor
  logic        hold_v = 1'b0;
  logic [12:0] hold_a;
  logic [7:0]  hold_d;
  logic        prev_fd = 1'b0;

  always @(negedge clk) begin
    if (FB_WE === 1'b1 && hold_v) begin
      check("stall_hold_addr", FB_ADDR, hold_a);
      check("stall_hold_data", FB_WDATA, hold_d);
    end
    hold_v = (FB_WE === 1'b1) && (FB_READY === 1'b0);
    hold_a = FB_ADDR;
    hold_d = FB_WDATA;

    if (FB_WE === 1'b1 && FB_READY === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected no write (t=%0t)",
                 FB_ADDR, FB_WDATA, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", FB_ADDR, e.addr);
        check("wr_data", FB_WDATA, e.data);
      end
    end

    if (FRAME_DONE === 1'b1) begin
      fd_cnt++;
      check("frame_done_width", prev_fd, 1'b0);
      check("frame_done_after_last_write", sb.size(), 0);
    end
    prev_fd = (FRAME_DONE === 1'b1);
  end

  task automatic step(input logic [1:0] m, input logic v, input logic [1:0] p);
    PPU_MODE = m;
    PX_valid = v;
    PX_OUT   = p;
    cur_mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_status();
    STATUS_CLR = 1'b1;
    step(cur_mode, 1'b0, 2'd0);
    STATUS_CLR = 1'b0;
    exp_err = 0;
  endtask

  task automatic start_frame();
    step(VBLANK, 1'b0, 2'd0);
    step(VBLANK, 1'b0, 2'd0);
  endtask

  // pat: 0 -> i%4, 1 -> all 3, 2 -> all 2, other -> random.
  // keep: how many of the line's bytes are expected to reach the frame buffer.
  task automatic do_line(input int y, input int n, input int pat, input bit gaps,
                         input int keep, input bit lat_chk);
    logic [1:0] px[$];
    logic [1:0] v;
    logic [7:0] b;
    int acc, nb;
    wr_t w;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       v = 2'(i % 4);
        1:       v = 2'd3;
        2:       v = 2'd2;
        default: v = 2'($urandom_range(0, 3));
      endcase
      px.push_back(v);
    end
    acc = (y < V) ? ((n < H) ? n : H) : 0;
    nb  = (acc + 3) / 4;
    for (int g = 0; g < nb && g < keep; g++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++)
        if (4 * g + j < acc) b = b | (8'(px[4 * g + j]) << (6 - 2 * j));
      w.addr = 13'(y * BPL + g);
      w.data = b;
      sb.push_back(w);
    end
    if (acc != H || n > acc) exp_err = 1;

    step(SCAN, 1'b0, 2'd0);
    step(SCAN, 1'b0, 2'd0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(DRAW, 1'b0, 2'($urandom_range(0, 3)));
      step(DRAW, 1'b1, px[i]);
      if (lat_chk && i == 2) check("fb_we_before_4th_pixel", FB_WE, 1'b0);
      if (lat_chk && i == 3) check("fb_we_after_4th_pixel", FB_WE, 1'b1);
    end
    step(HBLANK, 1'b0, 2'd0);
    step(HBLANK, 1'b0, 2'd0);
  endtask

  task automatic end_frame(input int exp_pulses);
    int fd0;
    int budget;
    fd0 = fd_cnt;
    budget = 0;
    step(VBLANK, 1'b0, 2'd0);
    while (fd_cnt == fd0 && budget < 200) begin
      step(VBLANK, 1'b0, 2'd0);
      budget++;
    end
    for (int i = 0; i < 4; i++) step(VBLANK, 1'b0, 2'd0);
    check("frame_done_pulses", fd_cnt - fd0, exp_pulses);
    check("writes_outstanding", sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    LCD_EN     = 1'b1;
    PPU_MODE   = HBLANK;
    PX_OUT     = 2'd0;
    PX_valid   = 1'b0;
    FB_READY   = 1'b1;
    STATUS_CLR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", FB_WE, 1'b0);
    check("rst_fb_addr", FB_ADDR, 13'd0);
    check("rst_fb_wdata", FB_WDATA, 8'd0);
    check("rst_frame_done", FRAME_DONE, 1'b0);
    check("rst_overflow", OVERFLOW, 1'b0);
    check("rst_line_err", LINE_ERR, 1'b0);
    rst = 1'b1;
    step(HBLANK, 1'b0, 2'd0);

    // 1: one line of 0,1,2,3 with FB_READY held high
    ready_ctl = 1;
    start_frame();
    do_line(0, H, 0, 1'b0, BPL, 1'b1);
    end_frame(1);
    check("t1_line_err", LINE_ERR, exp_err);

    // 2: full frame of colour 3
    ready_ctl = 2;
    start_frame();
    for (int y = 0; y < V; y++) do_line(y, H, 1, 1'b0, BPL, 1'b0);
    end_frame(1);
    check("t2_overflow", OVERFLOW, 1'b0);
    check("t2_line_err", LINE_ERR, 1'b0);

    // 3: short line sets LINE_ERR; next line starts at address 40
    start_frame();
    do_line(0, 6, 2, 1'b0, BPL, 1'b0);
    check("t3_line_err_set", LINE_ERR, 1'b1);
    clr_status();
    check("t3_line_err_cleared", LINE_ERR, 1'b0);
    do_line(1, H, 3, 1'b1, BPL, 1'b0);
    end_frame(1);
    check("t3_line_err_after", LINE_ERR, exp_err);

    // 4: stalled write port overflows the FIFO
    ready_ctl = 0;
    start_frame();
    do_line(0, 40, 3, 1'b0, D, 1'b0);
    for (int i = 0; i < 10; i++) step(HBLANK, 1'b0, 2'd0);
    check("t4_overflow", OVERFLOW, 1'b1);
    ready_ctl = 1;
    end_frame(1);
    check("t4_line_err", LINE_ERR, exp_err);
    clr_status();
    check("t4_overflow_cleared", OVERFLOW, 1'b0);
    check("t4_line_err_cleared", LINE_ERR, 1'b0);

    // 5: LCD disable mid-line with two bytes queued
    ready_ctl = 0;
    start_frame();
    begin
      int fd0;
      fd0 = fd_cnt;
      step(SCAN, 1'b0, 2'd0);
      step(SCAN, 1'b0, 2'd0);
      for (int i = 0; i < 8; i++) step(DRAW, 1'b1, 2'($urandom_range(0, 3)));
      check("t5_queued_we", FB_WE, 1'b1);
      LCD_EN = 1'b0;
      step(DRAW, 1'b0, 2'd0);
      check("t5_we_dropped", FB_WE, 1'b0);
      ready_ctl = 2;
      step(DRAW, 1'b0, 2'd0);
      LCD_EN = 1'b1;
      for (int i = 0; i < 8; i++) step(DRAW, 1'b1, 2'($urandom_range(0, 3)));
      step(HBLANK, 1'b0, 2'd0);
      step(HBLANK, 1'b0, 2'd0);
      check("t5_no_capture_before_start", FB_WE, 1'b0);
      check("t5_no_frame_done", fd_cnt - fd0, 0);
    end
    start_frame();
    do_line(0, 8, 3, 1'b0, BPL, 1'b0);
    end_frame(1);
    clr_status();

    // 6: reset during a stalled write
    ready_ctl = 0;
    start_frame();
    do_line(0, 8, 3, 1'b0, 0, 1'b0);
    check("t6_stalled_we", FB_WE, 1'b1);
    rst = 1'b0;
    step(HBLANK, 1'b0, 2'd0);
    check("t6_rst_fb_we", FB_WE, 1'b0);
    check("t6_rst_fb_addr", FB_ADDR, 13'd0);
    check("t6_rst_fb_wdata", FB_WDATA, 8'd0);
    check("t6_rst_line_err", LINE_ERR, 1'b0);
    check("t6_rst_overflow", OVERFLOW, 1'b0);
    check("t6_rst_frame_done", FRAME_DONE, 1'b0);
    rst = 1'b1;
    ready_ctl = 2;
    for (int i = 0; i < 20; i++) step(HBLANK, 1'b0, 2'd0);
    check("t6_no_stale_write", FB_WE, 1'b0);
    exp_err = 0;

    // 7: randomized frame: random lengths (some short, some overlong), gaps and stalls
    start_frame();
    for (int y = 0; y < 8; y++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? H : $urandom_range(1, H + 10);
      do_line(y, n, 3, 1'b1, BPL, 1'b0);
    end
    end_frame(1);
    check("t7_line_err", LINE_ERR, exp_err);
    check("t7_overflow", OVERFLOW, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
